// File: rtl/opb_register_bank_simulink2ppc_if.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_bank_simulink2ppc_if
// Brief    : OPB slave-side bus bundle for the user-to-PPC register bank.
//            Bit 0 of every vector is the MSB (OPB big-endian numbering).
// Revision : 1.0  initial release
// ============================================================================
interface opb_register_bank_simulink2ppc_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [0:AWIDTH-1]   OPB_ABus;
  logic [0:DWIDTH/8-1] OPB_BE;
  logic [0:DWIDTH-1]   OPB_DBus;
  logic                OPB_RNW;
  logic                OPB_select;
  logic                OPB_seqAddr;
  logic [0:DWIDTH-1]   Sl_DBus;
  logic                Sl_errAck;
  logic                Sl_retry;
  logic                Sl_toutSup;
  logic                Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface
`default_nettype wire

// File: rtl/opb_register_bank_simulink2ppc.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_bank_simulink2ppc
// Brief    : Bank of N_REGS user-to-PPC registers read over OPB, with atomic
//            capture, shadowed multi-word read (reading word 0 freezes the
//            rest), new-data/overrun status and a freeze/clear control word.
// Revision : 1.0  initial release
// ============================================================================
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h010B0100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B01FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_REGS       = 2,
  parameter              C_FAMILY     = "virtex5"
) (
  input  wire logic                    OPB_Clk,
  input  wire logic                    OPB_Rst_n,
  opb_register_bank_simulink2ppc_if.slave opb,
  input  wire logic [N_REGS*32-1:0]    user_data_in,
  input  wire logic                    user_valid,
  output logic                         frozen
);

  localparam int AW = C_OPB_AWIDTH;
  localparam int DW = C_OPB_DWIDTH;

  // Transfer tracking
  logic          ack_q;
  logic [DW-1:0] dbus_q;
  logic          rd_data_q;   // data-register read is being acked
  logic [3:0]    rd_idx_q;    // word index of that read
  logic          ctrl_wr_q;   // accepted control write is being acked
  logic [1:0]    wr_bits_q;   // [1] clear pulse, [0] freeze value

  // Bank state
  logic [31:0]       snap_q   [N_REGS];
  logic [31:0]       shadow_q [N_REGS];
  logic [N_REGS-1:0] newf_q, newf_d;
  logic              ovr_q, ovr_d;
  logic              freeze_q, freeze_d;

  // Address decode
  logic [AW-1:0] w_off, w_word;
  logic          w_hit, w_start, w_is_data, w_is_stat, w_is_ctrl;
  logic [31:0]   w_rdata, w_stat;

  assign w_hit     = opb.OPB_select
                  && (AW'(opb.OPB_ABus) >= AW'(C_BASEADDR))
                  && (AW'(opb.OPB_ABus) <= AW'(C_HIGHADDR));
  assign w_off     = AW'(opb.OPB_ABus) - AW'(C_BASEADDR);
  assign w_word    = w_off >> 2;
  // A new transfer starts only when not already acking, so acks never repeat
  assign w_start   = w_hit && !ack_q;
  assign w_is_data = (w_word <  AW'(N_REGS));
  assign w_is_stat = (w_word == AW'(N_REGS));
  assign w_is_ctrl = (w_word == AW'(N_REGS + 1));

  // Read multiplexer: word 0 is live, higher words come from the shadow copy
  always_comb begin
    w_stat             = '0;
    w_stat[N_REGS-1:0] = newf_q;
    w_stat[16]         = ovr_q;
    w_rdata            = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (w_word == AW'(i)) begin
        w_rdata = (i == 0) ? snap_q[0] : shadow_q[i];
      end
    end
    if (w_is_stat) w_rdata = w_stat;
    if (w_is_ctrl) w_rdata = {31'b0, freeze_q};
  end

  // Handshake: ack one cycle after a hit, latching what the ack edge must do
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q     <= 1'b0;
      dbus_q    <= '0;
      rd_data_q <= 1'b0;
      rd_idx_q  <= 4'd0;
      ctrl_wr_q <= 1'b0;
      wr_bits_q <= 2'b00;
    end else begin
      ack_q     <= w_start;
      dbus_q    <= (w_start && opb.OPB_RNW) ? DW'(w_rdata) : '0;
      rd_data_q <= w_start && opb.OPB_RNW && w_is_data;
      rd_idx_q  <= w_word[3:0];
      ctrl_wr_q <= w_start && !opb.OPB_RNW && w_is_ctrl && opb.OPB_BE[DW/8-1];
      wr_bits_q <= {opb.OPB_DBus[DW-2], opb.OPB_DBus[DW-1]};
    end
  end

  // Flag next state: clear first, read-clear next, capture-set last so set wins
  always_comb begin
    newf_d   = newf_q;
    ovr_d    = ovr_q;
    freeze_d = freeze_q;
    if (ctrl_wr_q && wr_bits_q[1]) begin
      newf_d = '0;
      ovr_d  = 1'b0;
    end
    if (rd_data_q) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (rd_idx_q == 4'(i)) newf_d[i] = 1'b0;
      end
    end
    if (user_valid) begin
      if (freeze_q) ovr_d  = 1'b1;
      else          newf_d = '1;
    end
    if (ctrl_wr_q) freeze_d = wr_bits_q[0];
  end

  // Flag and control registers
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      newf_q   <= '0;
      ovr_q    <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      newf_q   <= newf_d;
      ovr_q    <= ovr_d;
      freeze_q <= freeze_d;
    end
  end

  // Capture and shadow: shadow takes pre-edge snap values on a word-0 read ack
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        snap_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (rd_data_q && (rd_idx_q == 4'd0)) shadow_q[i] <= snap_q[i];
        if (user_valid && !freeze_q)         snap_q[i]   <= user_data_in[32*i +: 32];
      end
    end
  end

  assign opb.Sl_DBus    = dbus_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;
  assign frozen         = freeze_q;

  // Bus bits with no function in this slave
  logic w_unused;
  assign w_unused = ^{opb.OPB_seqAddr, opb.OPB_DBus[0:DW-3],
                      opb.OPB_BE[0:DW/8-2], ^C_FAMILY};

endmodule
`default_nettype wire

// File: doc/opb_register_bank_simulink2ppc.md
Name: opb_register_bank_simulink2ppc

Overview:
- Parametrised successor to the single read-only OPB software register: a bank of N_REGS 32-bit user-to-PPC registers read over OPB.
- Adds an atomic snapshot of all registers on a user strobe, and a consistent multi-word read: reading register 0 latches a shadow copy of the whole bank.
- Adds per-register new-data flags, an overrun flag and a writable control register (freeze, clear).
- User data is synchronous to OPB_Clk; any crossing into this domain happens upstream.

Parameters:
C_BASEADDR, 32'h010B0100, first byte address of the bank.
C_HIGHADDR, 32'h010B01FF, last byte address of the bank.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width (fixed at 32).
N_REGS, 2, number of data registers, 1..16.
C_FAMILY, "virtex5", target family (passed through, no functional effect).

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst_n  in  1  asynchronous reset, active-low
OPB_ABus  in  [0:31]  OPB address
OPB_BE  in  [0:3]  byte enables; BE[3] covers DBus[24:31]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1 = read, 0 = write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero when not acking
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
Sl_xferAck  out  1  transfer acknowledge
user_data_in  in  N_REGS*32  register i occupies bits [32i+31:32i]
user_valid  in  1  one-cycle strobe to capture all of user_data_in
frozen  out  1  mirrors the control freeze bit

Behaviour:
Address map
- Word index = (ABus - C_BASEADDR) >> 2. A hit requires OPB_select = 1 and C_BASEADDR <= ABus <= C_HIGHADDR.
- Index 0..N_REGS-1: data registers.
- Index N_REGS: status register.
- Index N_REGS+1: control register.
- Any other in-range index: reads return 0, writes are ignored; the transfer is still acked.
- DBus bit 31 is the LSB (weight 1).

Storage and reset
- snap[i]: live capture registers. shadow[i]: read copies for i >= 1.
- newf[N_REGS-1:0]: per-register new-data flags. ovr: overrun flag. freeze: control bit.
- All of the above and every output reset to 0 asynchronously while OPB_Rst_n = 0.

Capture
- user_valid = 1 and freeze = 0: every snap[i] loads its slice of user_data_in next edge; all newf bits set.
- user_valid = 1 and freeze = 1: snap holds its value; ovr is set.

OPB handshake
- Cycle T: hit = 1 and Sl_xferAck = 0.
- Cycle T+1: Sl_xferAck = 1 for exactly one cycle; for reads, Sl_DBus carries the data in that same cycle.
- Sl_xferAck is never high on two consecutive cycles.
- No ack is issued without a hit.
- Read latency is 1 cycle.

Read data
- Index 0: returns snap[0]. On the ack edge, shadow[i] <= snap[i] for i >= 1, using the pre-edge values.
- Index i >= 1: returns shadow[i], not snap[i].
- Status: value = newf (bit k at weight 2^k) | ovr << 16. Reading status has no side effect.
- Control: value = freeze at bit weight 1; bit weight 2 reads 0.
- A data read of index i clears newf[i] on the ack edge.

Writes
- Only control is writable, and only when OPB_BE[3] = 1.
- Bit weight 1 -> freeze.
- Bit weight 2 = 1 -> self-clearing pulse that clears all newf bits and ovr.
- Writes to any other index are acked and ignored.

Simultaneous events
- Capture in the same cycle as the read-0 ack edge: shadow gets the old snap values; snap gets the new data; newf[0] ends at 1 (set wins over read-clear).
- Capture in the same cycle as the clear pulse: newf ends at 1 (set wins).
- Freeze written in the same cycle as user_valid: the capture uses the freeze value from before the write.

Reset mid-transfer
- Sl_xferAck and Sl_DBus drop to 0 immediately.
- No ack is issued for the aborted transfer.

Test Plan:
1. Reset, then read index 0, 1, status -> each read gets exactly one Sl_xferAck, 1 cycle after select; data 0, 0, 0.
2. N_REGS=2; user_data_in = {32'h0000_0005, 32'h1234_5678} with one user_valid pulse; read status -> 0x3; read 0 -> 0x12345678; read status -> 0x2; read 1 -> 0x5; read status -> 0x0.
3. Capture {A=1, B=1}; read 0; capture {2, 2}; read 1 -> returns 1 (shadow), not 2.
4. Write control 0x1 with BE=4'b0001; pulse user_valid with new data -> read 0 returns the old value; status bit 16 = 1; frozen = 1. Write 0x2 -> status 0x0 and freeze cleared.
5. user_valid in the same cycle as the read-0 ack edge -> read returns the old value; status bit 0 remains 1.
6. Write control with BE=4'b1110 -> no change; read index N_REGS+2 -> 0 with ack; assert OPB_Rst_n = 0 during an ack cycle -> Sl_xferAck = 0 at once and all registers read 0 afterwards.
